// File: rtl/mod_arbiter_rr.sv
// mod_arbiter_rr: round-robin cache-line arbiter between N L1 clients and the single Sysbus
// master port. One line moves per transaction as DATA_WIDTH/BUS_WIDTH bus beats (beat 0 first).
// Tag bit 0 selects READ (1) or WRITE (0).
//
// Ports:
//   clk, reset        clock (posedge) and asynchronous active-high reset
//   cli_reqcyc/ack    per-client request valid / one-cycle grant pulse
//   cli_req/reqtag/   per-client address, tag, write line (client i at [i*W +: W])
//   cli_reqdata
//   cli_respcyc       per-client one-cycle completion pulse
//   cli_resp/resptag  shared returned line and tag, held until the next completion
//   sys_req/reqtag/   Sysbus address or write-data beat, tag, valid, accept
//   reqcyc/reqack
//   sys_resp/resptag/ Sysbus read-data beat, tag, valid; respack mirrors respcyc
//   respcyc/respack
//   protocol_err      sticky: a response beat arrived while no read was collecting beats
module mod_arbiter_rr #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned DATA_WIDTH  = 512,
   parameter int unsigned BUS_WIDTH   = 64,
   parameter int unsigned TAG_WIDTH   = 13
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CLIENTS-1:0]            cli_reqcyc,
   output logic [NUM_CLIENTS-1:0]            cli_reqack,
   input  logic [NUM_CLIENTS*BUS_WIDTH-1:0]  cli_req,
   input  logic [NUM_CLIENTS*TAG_WIDTH-1:0]  cli_reqtag,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_reqdata,
   output logic [NUM_CLIENTS-1:0]            cli_respcyc,
   output logic [DATA_WIDTH-1:0]             cli_resp,
   output logic [TAG_WIDTH-1:0]              cli_resptag,
   output logic [BUS_WIDTH-1:0]              sys_req,
   output logic [TAG_WIDTH-1:0]              sys_reqtag,
   output logic                              sys_reqcyc,
   input  logic                              sys_reqack,
   input  logic [BUS_WIDTH-1:0]              sys_resp,
   input  logic [TAG_WIDTH-1:0]              sys_resptag,
   input  logic                              sys_respcyc,
   output logic                              sys_respack,
   output logic                              protocol_err
);

   localparam int unsigned Beats = DATA_WIDTH / BUS_WIDTH;
   localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned CliW  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam logic [BeatW-1:0] LastBeat  = BeatW'(Beats - 1);
   localparam logic [CliW-1:0]  LastCli   = CliW'(NUM_CLIENTS - 1);

   if ((DATA_WIDTH % BUS_WIDTH) != 0) begin : g_bad_width
      $fatal(1, "DATA_WIDTH must be a multiple of BUS_WIDTH");
   end

   typedef enum logic [2:0] {StIdle, StAddr, StWr, StRd, StResp} state_e;

   state_e                 state_q, state_d;
   logic [CliW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CliW-1:0]        grant_q, grant_d;
   logic [BeatW-1:0]       beat_q, beat_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [DATA_WIDTH-1:0]  line_q, line_d;
   logic [NUM_CLIENTS-1:0] reqack_q, reqack_d;
   logic [NUM_CLIENTS-1:0] respcyc_q, respcyc_d;
   logic [DATA_WIDTH-1:0]  resp_q, resp_d;
   logic [TAG_WIDTH-1:0]   resptag_q, resptag_d;
   logic [BUS_WIDTH-1:0]   sys_req_q, sys_req_d;
   logic                   sys_reqcyc_q, sys_reqcyc_d;
   logic                   perr_q, perr_d;

   // Circular search for the first requester starting at rr_ptr_q.
   logic            found;
   logic [CliW-1:0] grant_idx;
   logic [CliW-1:0] cand;

   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         cand = CliW'((32'(rr_ptr_q) + i) % NUM_CLIENTS);
         if (!found && cli_reqcyc[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   logic [BeatW-1:0] beat_inc;
   assign beat_inc = beat_q + BeatW'(1);

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      beat_d       = beat_q;
      tag_d        = tag_q;
      line_d       = line_q;
      reqack_d     = '0;
      respcyc_d    = '0;
      resp_d       = resp_q;
      resptag_d    = resptag_q;
      sys_req_d    = sys_req_q;
      sys_reqcyc_d = sys_reqcyc_q;
      // Beats are only expected while collecting a read line; anything else is dropped.
      perr_d       = perr_q | (sys_respcyc && (state_q != StRd));

      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d             = grant_idx;
               rr_ptr_d            = (grant_idx == LastCli) ? '0 : grant_idx + CliW'(1);
               reqack_d[grant_idx] = 1'b1;
               sys_req_d           = cli_req[32'(grant_idx) * BUS_WIDTH +: BUS_WIDTH];
               tag_d               = cli_reqtag[32'(grant_idx) * TAG_WIDTH +: TAG_WIDTH];
               line_d              = cli_reqdata[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
               sys_reqcyc_d        = 1'b1;
               state_d             = StAddr;
            end
         end
         StAddr: begin
            if (sys_reqack) begin
               beat_d = '0;
               if (tag_q[0]) begin
                  sys_reqcyc_d = 1'b0;
                  state_d      = StRd;
               end else begin
                  sys_req_d = line_q[BUS_WIDTH-1:0];
                  state_d   = StWr;
               end
            end
         end
         StWr: begin
            if (sys_reqack) begin
               if (beat_q == LastBeat) begin
                  sys_reqcyc_d       = 1'b0;
                  respcyc_d[grant_q] = 1'b1;
                  resptag_d          = tag_q;
                  beat_d             = '0;
                  state_d            = StResp;
               end else begin
                  beat_d    = beat_inc;
                  sys_req_d = line_q[32'(beat_inc) * BUS_WIDTH +: BUS_WIDTH];
               end
            end
         end
         StRd: begin
            if (sys_respcyc) begin
               line_d[32'(beat_q) * BUS_WIDTH +: BUS_WIDTH] = sys_resp;
               beat_d = beat_inc;
               if (beat_q == LastBeat) begin
                  respcyc_d[grant_q] = 1'b1;
                  resptag_d          = sys_resptag;
                  resp_d             = line_d;
                  beat_d             = '0;
                  state_d            = StResp;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         beat_q       <= '0;
         tag_q        <= '0;
         line_q       <= '0;
         reqack_q     <= '0;
         respcyc_q    <= '0;
         resp_q       <= '0;
         resptag_q    <= '0;
         sys_req_q    <= '0;
         sys_reqcyc_q <= 1'b0;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         beat_q       <= beat_d;
         tag_q        <= tag_d;
         line_q       <= line_d;
         reqack_q     <= reqack_d;
         respcyc_q    <= respcyc_d;
         resp_q       <= resp_d;
         resptag_q    <= resptag_d;
         sys_req_q    <= sys_req_d;
         sys_reqcyc_q <= sys_reqcyc_d;
         perr_q       <= perr_d;
      end
   end

   assign cli_reqack   = reqack_q;
   assign cli_respcyc  = respcyc_q;
   assign cli_resp     = resp_q;
   assign cli_resptag  = resptag_q;
   assign sys_req      = sys_req_q;
   assign sys_reqtag   = tag_q;
   assign sys_reqcyc   = sys_reqcyc_q;
   assign sys_respack  = sys_respcyc;
   assign protocol_err = perr_q;

endmodule

// File: tb/tb_mod_arbiter_rr.sv
// Randomised scoreboard bench for mod_arbiter_rr (3 clients, 512-bit lines, 64-bit bus).
module tb_mod_arbiter_rr;

   localparam int N     = 3;
   localparam int DW    = 512;
   localparam int BW    = 64;
   localparam int TW    = 13;
   localparam int BEATS = DW / BW;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    cli_reqcyc, cli_reqack, cli_respcyc;
   logic [N*BW-1:0] cli_req;
   logic [N*TW-1:0] cli_reqtag;
   logic [N*DW-1:0] cli_reqdata;
   logic [DW-1:0]   cli_resp;
   logic [TW-1:0]   cli_resptag;
   logic [BW-1:0]   sys_req;
   logic [TW-1:0]   sys_reqtag;
   logic            sys_reqcyc, sys_reqack;
   logic [BW-1:0]   sys_resp;
   logic [TW-1:0]   sys_resptag;
   logic            sys_respcyc, sys_respack, protocol_err;
   logic            bus_respcyc, err_pulse;

   assign sys_respcyc = bus_respcyc | err_pulse;

   mod_arbiter_rr #(
      .NUM_CLIENTS(N),
      .DATA_WIDTH (DW),
      .BUS_WIDTH  (BW),
      .TAG_WIDTH  (TW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cli_reqcyc  (cli_reqcyc),
      .cli_reqack  (cli_reqack),
      .cli_req     (cli_req),
      .cli_reqtag  (cli_reqtag),
      .cli_reqdata (cli_reqdata),
      .cli_respcyc (cli_respcyc),
      .cli_resp    (cli_resp),
      .cli_resptag (cli_resptag),
      .sys_req     (sys_req),
      .sys_reqtag  (sys_reqtag),
      .sys_reqcyc  (sys_reqcyc),
      .sys_reqack  (sys_reqack),
      .sys_resp    (sys_resp),
      .sys_resptag (sys_resptag),
      .sys_respcyc (sys_respcyc),
      .sys_respack (sys_respack),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            client;
      logic [TW-1:0] tag;
      logic [DW-1:0] line;
   } resp_t;

   typedef struct {
      logic [BW-1:0] addr;
      logic [TW-1:0] tag;
      bit            rd;
      logic [DW-1:0] line;
      logic [TW-1:0] rtag;
      int            abort;
   } sys_t;

   resp_t         respq[$];
   sys_t          sysq[$];
   int            checks = 0;
   int            failures = 0;
   int            model_ptr;
   logic [DW-1:0] model_last;
   bit            zero_wait;
   int            aborts_done = 0;
   int            last_resp_cyc = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got timeout/unexpected expected event", name);
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] l;
      for (int k = 0; k < DW / 32; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   // Request set is held until granted, so the whole grant order follows from the
   // pointer and the mask: repeatedly take the first pending client from the pointer.
   task automatic issue_round(input logic [N-1:0] mask, input int mode, input int abort_beats);
      logic [BW-1:0] a_addr[N];
      logic [TW-1:0] a_tag[N];
      bit            a_rd[N];
      logic [DW-1:0] a_line[N];
      logic [N-1:0]  pend;
      sys_t          s;
      resp_t         r;
      int            c;
      for (int i = 0; i < N; i++) begin
         a_addr[i] = {$urandom, $urandom} & ~64'h3f;
         a_tag[i]  = TW'($urandom);
         a_rd[i]   = (mode == 0) ? bit'($urandom_range(0, 1)) : (mode == 1);
         a_tag[i][0] = a_rd[i];
         a_line[i] = rand_line();
         if (mask[i]) begin
            cli_req[i*BW +: BW]     = a_addr[i];
            cli_reqtag[i*TW +: TW]  = a_tag[i];
            cli_reqdata[i*DW +: DW] = a_line[i];
         end
      end
      pend = mask;
      while (pend != 0) begin
         c = -1;
         for (int k = 0; k < N; k++)
            if (c < 0 && pend[(model_ptr + k) % N]) c = (model_ptr + k) % N;
         pend[c]   = 1'b0;
         model_ptr = (c + 1) % N;
         s.addr  = a_addr[c];
         s.tag   = a_tag[c];
         s.rd    = a_rd[c];
         s.abort = abort_beats;
         r.client = c;
         if (a_rd[c]) begin
            s.line     = rand_line();
            s.rtag     = TW'($urandom);
            r.line     = s.line;
            r.tag      = s.rtag;
            model_last = s.line;
         end else begin
            s.line = a_line[c];
            s.rtag = '0;
            r.line = model_last;
            r.tag  = a_tag[c];
         end
         sysq.push_back(s);
         if (abort_beats == 0) respq.push_back(r);
      end
      cli_reqcyc = mask;
   endtask

   task automatic drain();
      int n = 0;
      while ((cli_reqcyc != 0 || respq.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
         if (cli_reqack != 0) begin
            chk("reqack_onehot", DW'($onehot(cli_reqack)), 1);
            chk("reqack_to_requester", cli_reqack & ~cli_reqcyc, 0);
            cli_reqcyc = cli_reqcyc & ~cli_reqack;
         end
      end
      if (cli_reqcyc != 0 || respq.size() != 0) fail_now("drain_timeout");
      repeat (2) @(negedge clk);
      chk("sys_queue_drained", sysq.size(), 0);
   endtask

   task automatic bus_ack(input logic [BW-1:0] held);
      int w = zero_wait ? 0 : $urandom_range(0, 2);
      sys_reqack = 1'b0;
      repeat (w) begin
         @(negedge clk);
         chk("held_reqcyc", sys_reqcyc, 1);
         chk("held_sys_req", sys_req, held);
      end
      sys_reqack = 1'b1;
      @(negedge clk);
      sys_reqack = 1'b0;
   endtask

   // Sysbus slave model.
   initial begin
      sys_t s;
      int   w;
      int   nb;
      sys_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      sys_resp    = '0;
      sys_resptag = '0;
      forever begin
         @(negedge clk);
         if (!reset && sys_reqcyc) begin
            if (sysq.size() == 0) begin
               fail_now("unexpected_sys_req");
            end else begin
               s = sysq.pop_front();
               chk("sys_addr", sys_req, s.addr);
               chk("sys_reqtag", sys_reqtag, s.tag);
               bus_ack(s.addr);
               if (!s.rd) begin
                  for (int k = 0; k < BEATS; k++) begin
                     chk("wr_reqcyc", sys_reqcyc, 1);
                     chk("wr_beat", sys_req, s.line[k*BW +: BW]);
                     bus_ack(s.line[k*BW +: BW]);
                  end
                  chk("wr_end_reqcyc", sys_reqcyc, 0);
               end else begin
                  chk("rd_reqcyc_low", sys_reqcyc, 0);
                  nb = (s.abort != 0) ? s.abort : BEATS;
                  for (int k = 0; k < nb; k++) begin
                     w = zero_wait ? 0 : $urandom_range(0, 2);
                     repeat (w) @(negedge clk);
                     bus_respcyc = 1'b1;
                     sys_resp    = s.line[k*BW +: BW];
                     sys_resptag = (k == BEATS - 1) ? s.rtag : TW'($urandom);
                     @(negedge clk);
                     bus_respcyc = 1'b0;
                  end
                  if (s.abort != 0) aborts_done++;
               end
            end
         end
      end
   end

   // Response monitor.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (!reset && cli_respcyc != 0) begin
            if (respq.size() == 0) begin
               fail_now("unexpected_resp");
            end else begin
               e = respq.pop_front();
               chk("resp_client", cli_respcyc, DW'(1) << e.client);
               chk("resp_tag", cli_resptag, e.tag);
               chk("resp_line", cli_resp, e.line);
               last_resp_cyc = cyc;
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_reqack"}, cli_reqack, 0);
      chk({tag, "_respcyc"}, cli_respcyc, 0);
      chk({tag, "_sys_reqcyc"}, sys_reqcyc, 0);
      chk({tag, "_sys_req"}, sys_req, 0);
      chk({tag, "_sys_reqtag"}, sys_reqtag, 0);
      chk({tag, "_resp"}, cli_resp, 0);
      chk({tag, "_resptag"}, cli_resptag, 0);
      chk({tag, "_perr"}, protocol_err, 0);
   endtask

   initial begin
      int t0;
      int ab;
      int n;
      reset = 1'b1;
      cli_reqcyc = '0;
      cli_req = '0;
      cli_reqtag = '0;
      cli_reqdata = '0;
      err_pulse = 1'b0;
      zero_wait = 1'b0;
      model_ptr = 0;
      model_last = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Simultaneous 0 and 1 straight after reset.
      issue_round(3'b011, 0, 0);
      drain();

      zero_wait = 1'b1;
      t0 = cyc;
      issue_round(3'b010, 1, 0);
      drain();
      chk("read_latency", last_resp_cyc - t0, 10);
      t0 = cyc;
      issue_round(3'b001, 2, 0);
      drain();
      chk("write_latency", last_resp_cyc - t0, 10);
      zero_wait = 1'b0;

      repeat (2) begin
         issue_round(3'b111, 0, 0);
         drain();
      end
      repeat (20) begin
         issue_round(N'($urandom_range(1, 7)), 0, 0);
         drain();
      end

      // Stray response beat while idle.
      chk("perr_clear", protocol_err, 0);
      err_pulse = 1'b1;
      #1;
      chk("respack_follows_hi", sys_respack, 1);
      @(negedge clk);
      err_pulse = 1'b0;
      #1;
      chk("respack_follows_lo", sys_respack, 0);
      chk("perr_set", protocol_err, 1);
      issue_round(3'b100, 1, 0);
      drain();
      chk("perr_sticky", protocol_err, 1);

      // Reset in the middle of a read after 3 beats.
      ab = aborts_done;
      issue_round(3'b001, 1, 3);
      drain();
      n = 0;
      while (aborts_done == ab && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (aborts_done == ab) fail_now("abort_timeout");
      repeat (2) @(negedge clk);
      chk("midread_no_resp", cli_respcyc, 0);
      reset = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      model_ptr = 0;
      model_last = '0;
      @(negedge clk);

      issue_round(3'b001, 1, 0);
      drain();
      repeat (5) begin
         issue_round(N'($urandom_range(1, 7)), 0, 0);
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mod_arbiter_rr.md
Name: mod_arbiter_rr

Overview:
Parametrised N-client cache-line arbiter between L1 caches (ICache, DCache, future prefetcher/TLB walker) and the single Sysbus master port. Grants clients round-robin and moves one cache line per transaction as DATA_WIDTH/BUS_WIDTH bus beats. Handles both read fills and write-backs, and flags Sysbus protocol violations.

Parameters:
NUM_CLIENTS, 2, number of requesting clients (>=1); index 0 = highest priority after reset.
DATA_WIDTH, 512, cache line width in bits; must be a multiple of BUS_WIDTH (elaboration $fatal otherwise).
BUS_WIDTH, 64, Sysbus data/address beat width.
TAG_WIDTH, 13, Sysbus tag width; tag bit 0 = 1 means READ, 0 means WRITE.

Ports:
clk  in  1  clock, all logic on posedge.
reset  in  1  asynchronous, active-high reset.
cli_reqcyc  in  NUM_CLIENTS  per-client request valid.
cli_reqack  out  NUM_CLIENTS  per-client one-cycle grant/accept pulse.
cli_req  in  NUM_CLIENTS*BUS_WIDTH  per-client line address; client i at [i*BUS_WIDTH +: BUS_WIDTH].
cli_reqtag  in  NUM_CLIENTS*TAG_WIDTH  per-client tag, same slicing.
cli_reqdata  in  NUM_CLIENTS*DATA_WIDTH  per-client write line, same slicing.
cli_respcyc  out  NUM_CLIENTS  per-client one-cycle completion pulse.
cli_resp  out  DATA_WIDTH  returned line (shared; valid when any cli_respcyc bit is high).
cli_resptag  out  TAG_WIDTH  returned tag (shared).
sys_req  out  BUS_WIDTH  Sysbus address/write-data beat.
sys_reqtag  out  TAG_WIDTH  Sysbus request tag.
sys_reqcyc  out  1  Sysbus request valid.
sys_reqack  in  1  Sysbus request accepted.
sys_resp  in  BUS_WIDTH  Sysbus read-data beat.
sys_resptag  in  TAG_WIDTH  Sysbus response tag.
sys_respcyc  in  1  Sysbus response beat valid.
sys_respack  out  1  combinationally equal to sys_respcyc (always accepts).
protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (async, any state): state=IDLE; rr_ptr=0; beat=0; all outputs 0 except sys_respack (follows sys_respcyc). In-flight transaction abandoned silently.
- BEATS = DATA_WIDTH/BUS_WIDTH. Beat k occupies line bits [k*BUS_WIDTH +: BUS_WIDTH]; beat 0 is transferred first.
- IDLE: if any cli_reqcyc is set, grant g = first set index searching circularly from rr_ptr. Next cycle: cli_reqack[g]=1 for exactly one cycle; addr/tag/write line latched; sys_req=addr; sys_reqtag=tag; sys_reqcyc=1; rr_ptr=(g+1) mod NUM_CLIENTS; state=ADDR.
- cli_reqcyc is ignored outside IDLE. Clients drop reqcyc after seeing reqack.
- ADDR: hold sys_req/sys_reqtag/sys_reqcyc until sys_reqack.
  - Read on ack: sys_reqcyc=0; beat=0; state goes to RD.
  - Write on ack: sys_req=beat 0 data; sys_reqcyc=1; state goes to WR.
- WR: each cycle with sys_reqack=1 advances to the next beat on sys_req. When the last beat (BEATS-1) is acked: sys_reqcyc=0, state goes to RESP. No ack means hold the beat.
- RD: each cycle with sys_respcyc=1 stores sys_resp into slot beat and increments beat. On the last beat, capture sys_resptag and go to RESP. Read data is never forwarded before the full line arrives.
- RESP (1 cycle): cli_respcyc[g]=1; cli_resptag = captured sys_resptag (read) or request tag (write); cli_resp = assembled line (read) or unchanged (write). Next state is IDLE.
- cli_resp/cli_resptag hold their value until the next RESP. cli_respcyc is 0 in all other states.
- Min read latency: request sampled at cycle 0, ack at cycle 1, beats at cycles 2..9, cli_respcyc at cycle 10 (BEATS=8, zero-wait bus). Write is the same: beats acked at cycles 2..9, cli_respcyc at cycle 10.
- sys_respcyc outside RD (IDLE/ADDR/WR/RESP): beat dropped; protocol_err set to 1 and held until reset.
- New request arriving in the RESP cycle is sampled in the following IDLE cycle. No back-to-back grant in the same cycle as RESP.
- Fairness: any continuously requesting client is granted within NUM_CLIENTS transactions.

Test Plan:
- Single read: client 1 reads addr 0x1000, tag[0]=1; bus returns beats 0x0..0x7 with no wait states -> cli_respcyc[1] at cycle 10; cli_resp[63:0]=0, cli_resp[511:448]=7; cli_resptag = bus tag.
- Write-back: client 0 writes line with beat k = 0xA0+k; reqack stalled 2 cycles on beat 3 -> sys_req sequence 0x1000, 0xA0..0xA7 with 0xA3 held 3 cycles; cli_respcyc[0] one cycle after the 0xA7 ack.
- Round-robin: NUM_CLIENTS=3, all reqcyc held high for 6 transactions -> grant order 0,1,2,0,1,2.
- Simultaneous: clients 0 and 1 both request after reset -> 0 granted first, 1 granted next; the grant is never to the same client twice in a row.
- Protocol error: sys_respcyc pulsed while in IDLE -> protocol_err=1 and stays 1 through a subsequent good read.
- Reset mid-read after 3 beats -> all outputs 0, state IDLE, no cli_respcyc. A new request after reset completes normally with 8 fresh beats.
